instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end stage that supplies the single-cycle datapath with 16-bit instructions. It owns the program counter and fetches each instruction as two bytes from the byte-wide instruction memory, using a request/acknowledge handshake. Completed instructions go into a 2-entry queue that feeds the datapath over a valid/ready handshake. The datapath's next-address logic redirects the fetch unit on a taken branch or a jump; a redirect flushes all fetched and in-flight work.

## Interface

- RESET_PC, 16'h0000, byte address of the first instruction fetched after reset (bit 0 must be 0)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_req  out  1  byte read request; held high with a stable address until acknowledged
- imem_addr  out  16  byte address of the current request
- imem_ack  in  1  request completes this cycle; imem_rdata is valid; may be high in the same cycle as imem_req rises
- imem_rdata  in  8  returned byte
- instr  out  16  head-of-queue instruction; bits [15:8] come from the even byte, bits [7:0] from the odd byte
- instr_pc  out  16  byte address of instr
- instr_valid  out  1  queue is not empty
- instr_ready  in  1  datapath accepts instr this cycle
- redirect  in  1  taken branch or jump
- redirect_pc  in  16  target address; bit 0 is ignored and treated as 0
- fetch_pc  out  16  address of the instruction currently being fetched (or next to be fetched)

## Operation

- FSM states:
  - FETCH_HI: requests byte at pc.
  - FETCH_LO: requests byte at pc+1.
  - STALL: queue is full; no request is issued.
  - DRAIN: a redirect arrived while a request was outstanding; the unit waits for the ack and discards the data.
- FETCH_HI transitions:
  - On ack, latch imem_rdata into hi_byte and move to FETCH_LO.
- FETCH_LO transitions:
  - On ack, push {pc, hi_byte, imem_rdata} into the queue and set pc <= pc + 2.
  - Next state is FETCH_HI if the post-push count is below 2, otherwise STALL.
- STALL transitions:
  - Move to FETCH_HI in the cycle after a pop makes count < 2.
- Queue: 2-entry FIFO of {pc, instr}.
  - Pop occurs when instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed.
  - count stays in 0..2.
- PC arithmetic: 16-bit, modulo 2^16.
  - 16'hFFFE + 2 = 16'h0000.
  - The odd-byte address 16'hFFFF is fetched normally.
- Redirect (highest priority):
  - Sets pc <= {redirect_pc[15:1], 1'b0}.
  - Clears the queue (count <= 0) and discards hi_byte.
  - Next state:
    - DRAIN if imem_req is high and imem_ack is low in the redirect cycle.
    - Otherwise FETCH_HI. An ack arriving in the redirect cycle is discarded.
- DRAIN: on ack, discard the data and move to FETCH_HI (pc already holds the target).
- A redirect during DRAIN updates pc again and stays in DRAIN.
- Redirect together with instr_valid && instr_ready: the transfer of the head counts as complete, then the flush applies.
- Redirect overrides a simultaneous push: the fetched instruction is dropped.
- imem_req is high in FETCH_HI, FETCH_LO and DRAIN. imem_addr is:
  - pc in FETCH_HI
  - pc+1 in FETCH_LO
  - the held outstanding address in DRAIN
- fetch_pc = pc.

## Timing

- Reset (asynchronous assert, synchronous effect on release):
  - state FETCH_HI, pc = RESET_PC, count 0
  - instr_valid 0, instr 16'h0000, instr_pc 16'h0000
  - imem_req 0, imem_addr RESET_PC, fetch_pc RESET_PC
- First imem_req is asserted in the first cycle after reset_n deasserts.
- Zero-wait memory (ack in the same cycle as req):
  - One instruction every 2 cycles.
  - instr_valid rises 2 cycles after the first request cycle.
- Redirect sampled at edge N with no outstanding request:
  - imem_req/imem_addr = target in cycle N+1.
  - instr_valid low in N+1.
  - First target instruction is valid in cycle N+3 (zero-wait memory).
- With W wait cycles per byte, each byte takes W+1 cycles.
- Reset asserted mid-request drops the request immediately; the memory side must tolerate the abandoned request.
- Outputs are registered except:
  - imem_req/imem_addr, which are decoded from state and pc
  - instr/instr_pc/instr_valid, which are driven from the queue head

## Test plan

- Reset and zero-wait streaming:
  - Stimulus: memory holds 2B A1 at bytes 0–1 and 3C 45 at bytes 2–3; instr_ready=1.
  - Required response: instr 16'h2BA1 with instr_pc 0, then 16'h3C45 with instr_pc 2, one every 2 cycles; first valid 2 cycles after the first request.
- Backpressure:
  - Stimulus: instr_ready=0.
  - Required response: after 2 instructions, instr_valid stays 1 and imem_req drops (STALL).
  - Stimulus: a single instr_ready pulse.
  - Required response: head advances; fetch resumes the next cycle at pc 4; order is preserved with no duplicates.
- Redirect with idle memory:
  - Stimulus: redirect=1, redirect_pc=16'h0041.
  - Required response: queue flushed; next imem_addr 16'h0040, then 16'h0041; next instr_pc 16'h0040.
- Redirect with an outstanding request:
  - Stimulus: memory with 3 wait cycles; redirect during FETCH_LO.
  - Required response: the pending ack is consumed and discarded (DRAIN); the next request goes to the target; no stale instruction is ever valid.
- Wrap-around:
  - Stimulus: redirect to 16'hFFFE.
  - Required response: bytes FFFE and FFFF are fetched with instr_pc 16'hFFFE; the next fetch address is 16'h0000.
- Simultaneous events:
  - Stimulus: redirect together with a pop, and redirect together with a final-byte ack.
  - Required response: the pop counts as complete, the pushed instruction is dropped, and count = 0 after the edge.
- Reset mid-fetch:
  - Stimulus: assert reset_n=0 in FETCH_LO.
  - Required response: all outputs go to their reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_fetch_unit                                                     |
// | Fetches 16-bit instructions as byte pairs into a 2-entry queue.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [7:0]  imem_rdata_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic [15:0] fetch_pc_o
);

  typedef enum logic [1:0] {
    FETCH_HI = 2'd0,
    FETCH_LO = 2'd1,
    STALL    = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  hi_q, hi_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [15:0] pc1_q, pc1_d, ins1_q, ins1_d;

  logic        w_req;
  logic        w_pop;
  logic        w_push;
  logic [1:0]  w_count_pop;
  logic [15:0] w_addr;

  always_comb begin
    // run_q keeps the request low until the first edge after reset release
    w_req = run_q && (state_q != STALL);
    case (state_q)
      FETCH_LO: w_addr = pc_q + 16'd1;
      DRAIN:    w_addr = hold_q;
      default:  w_addr = pc_q;
    endcase
    w_pop       = (count_q != 2'd0) && instr_ready_i;
    w_push      = w_req && (state_q == FETCH_LO) && imem_ack_i && !redirect_i;
    w_count_pop = count_q - {1'b0, w_pop};

    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    hi_d    = hi_q;
    count_d = w_count_pop + {1'b0, w_push};
    pc0_d   = pc0_q;
    ins0_d  = ins0_q;
    pc1_d   = pc1_q;
    ins1_d  = ins1_q;

    if (w_pop) begin
      pc0_d  = pc1_q;
      ins0_d = ins1_q;
    end
    if (w_push) begin
      if (w_count_pop == 2'd0) begin
        pc0_d  = pc_q;
        ins0_d = {hi_q, imem_rdata_i};
      end else begin
        pc1_d  = pc_q;
        ins1_d = {hi_q, imem_rdata_i};
      end
    end

    if (redirect_i) begin
      pc_d    = redirect_pc_i & 16'hFFFE;
      hi_d    = 8'h00;
      count_d = 2'd0;
      hold_d  = w_addr;
      state_d = (w_req && !imem_ack_i) ? DRAIN : FETCH_HI;
    end else begin
      case (state_q)
        FETCH_HI: if (w_req && imem_ack_i) begin
          hi_d    = imem_rdata_i;
          state_d = FETCH_LO;
        end
        FETCH_LO: if (w_req && imem_ack_i) begin
          pc_d    = pc_q + 16'd2;
          state_d = (w_count_pop == 2'd0) ? FETCH_HI : STALL;
        end
        STALL: if (w_pop) state_d = FETCH_HI;
        DRAIN: if (imem_ack_i) state_d = FETCH_HI;
        default: state_d = FETCH_HI;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= FETCH_HI;
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      hold_q  <= RESET_PC;
      hi_q    <= 8'h00;
      count_q <= 2'd0;
      pc0_q   <= 16'h0000;
      ins0_q  <= 16'h0000;
      pc1_q   <= 16'h0000;
      ins1_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      pc0_q   <= pc0_d;
      ins0_q  <= ins0_d;
      pc1_q   <= pc1_d;
      ins1_q  <= ins1_d;
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = w_addr;
  assign instr_o       = ins0_q;
  assign instr_pc_o    = pc0_q;
  assign instr_valid_o = (count_q != 2'd0);
  assign fetch_pc_o    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_fetch_unit                                                  |
// | Directed bench with a wait-state byte memory model.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] fetch_pc;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;

  instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clock_i       (clock),
    .reset_n_i     (reset_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .fetch_pc_o    (fetch_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h2B;
      16'h0001: return 8'hA1;
      16'h0002: return 8'h3C;
      16'h0003: return 8'h45;
      default:  return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Acks after wait_cfg wait cycles; zero waits acks in the request cycle
  assign imem_ack   = imem_req && (wcnt == wait_cfg);
  assign imem_rdata = mem_byte(imem_addr);

  always @(posedge clock) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {15'd0, imem_req},    16'h0000);
    chk({tag, "_addr"},  imem_addr,            16'h0000);
    chk({tag, "_fpc"},   fetch_pc,             16'h0000);
    chk({tag, "_valid"}, {15'd0, instr_valid}, 16'h0000);
    chk({tag, "_instr"}, instr,                16'h0000);
    chk({tag, "_ipc"},   instr_pc,             16'h0000);
  endtask

  initial begin
    // ---- reset state, then zero-wait streaming ----
    tick(); tick();
    chk_reset("rst");
    reset_n = 1'b1;
    tick();                                     // C1
    chk("s_c1_req",  {15'd0, imem_req}, 16'h0001);
    chk("s_c1_addr", imem_addr, 16'h0000);
    chk("s_c1_valid", {15'd0, instr_valid}, 16'h0000);
    tick();                                     // C2
    chk("s_c2_addr", imem_addr, 16'h0001);
    chk("s_c2_valid", {15'd0, instr_valid}, 16'h0000);
    tick();                                     // C3
    chk("s_c3_valid", {15'd0, instr_valid}, 16'h0001);
    chk("s_c3_instr", instr, 16'h2BA1);
    chk("s_c3_ipc",   instr_pc, 16'h0000);
    chk("s_c3_addr",  imem_addr, 16'h0002);
    tick();                                     // C4
    chk("s_c4_valid", {15'd0, instr_valid}, 16'h0000);
    chk("s_c4_addr",  imem_addr, 16'h0003);
    tick();                                     // C5
    chk("s_c5_valid", {15'd0, instr_valid}, 16'h0001);
    chk("s_c5_instr", instr, 16'h3C45);
    chk("s_c5_ipc",   instr_pc, 16'h0002);
    tick();                                     // C6: FETCH_LO of byte 5
    chk("s_c6_addr", imem_addr, 16'h0005);

    // ---- reset mid-fetch ----
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    instr_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    // ---- backpressure ----
    tick();                                     // C1
    chk("b_c1_addr", imem_addr, 16'h0000);
    tick(); tick();                             // C3
    chk("b_c3_instr", instr, 16'h2BA1);
    tick(); tick();                             // C5: full -> STALL
    chk("b_c5_req",   {15'd0, imem_req}, 16'h0000);
    chk("b_c5_valid", {15'd0, instr_valid}, 16'h0001);
    chk("b_c5_instr", instr, 16'h2BA1);
    chk("b_c5_fpc",   fetch_pc, 16'h0004);
    tick();                                     // C6
    chk("b_c6_req",   {15'd0, imem_req}, 16'h0000);
    chk("b_c6_ipc",   instr_pc, 16'h0000);
    instr_ready = 1'b1;
    tick();                                     // C7
    instr_ready = 1'b0;
    chk("b_c7_instr", instr, 16'h3C45);
    chk("b_c7_ipc",   instr_pc, 16'h0002);
    chk("b_c7_req",   {15'd0, imem_req}, 16'h0001);
    chk("b_c7_addr",  imem_addr, 16'h0004);
    tick(); tick();                             // C9: full again
    chk("b_c9_req",   {15'd0, imem_req}, 16'h0000);
    chk("b_c9_instr", instr, 16'h3C45);
    instr_ready = 1'b1;
    tick();                                     // C10
    instr_ready = 1'b0;
    chk("b_c10_instr", instr, 16'hA1A0);
    chk("b_c10_ipc",   instr_pc, 16'h0004);
    chk("b_c10_addr",  imem_addr, 16'h0006);

    // ---- redirect with idle memory ----
    redirect    = 1'b1;
    redirect_pc = 16'h0041;
    tick();                                     // N+1
    redirect = 1'b0;
    chk("r_n1_valid", {15'd0, instr_valid}, 16'h0000);
    chk("r_n1_req",   {15'd0, imem_req}, 16'h0001);
    chk("r_n1_addr",  imem_addr, 16'h0040);
    chk("r_n1_fpc",   fetch_pc, 16'h0040);
    tick();                                     // N+2
    chk("r_n2_addr",  imem_addr, 16'h0041);
    chk("r_n2_valid", {15'd0, instr_valid}, 16'h0000);
    tick();                                     // N+3
    chk("r_n3_valid", {15'd0, instr_valid}, 16'h0001);
    chk("r_n3_instr", instr, 16'hE5E4);
    chk("r_n3_ipc",   instr_pc, 16'h0040);

    // ---- redirect with outstanding request (3 waits) and wrap-around ----
    wait_cfg = 3;
    tick(); tick();
    chk("d_wait_addr", imem_addr, 16'h0042);
    tick(); tick();                             // FETCH_LO, byte 0x43 outstanding
    chk("d_lo_addr", imem_addr, 16'h0043);
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();                                     // DRAIN
    redirect = 1'b0;
    chk("d_dr_valid", {15'd0, instr_valid}, 16'h0000);
    chk("d_dr_req",   {15'd0, imem_req}, 16'h0001);
    chk("d_dr_addr",  imem_addr, 16'h0043);
    chk("d_dr_fpc",   fetch_pc, 16'hFFFE);
    tick();                                     // ack arrives for discarded byte
    chk("d_ack_addr",  imem_addr, 16'h0043);
    chk("d_ack_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    wait_cfg = 0;
    chk("w_hi_addr",  imem_addr, 16'hFFFE);
    chk("w_hi_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("w_lo_addr",  imem_addr, 16'hFFFF);
    chk("w_lo_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("w_instr", instr, 16'h5B5A);
    chk("w_ipc",   instr_pc, 16'hFFFE);
    chk("w_addr",  imem_addr, 16'h0000);
    chk("w_fpc",   fetch_pc, 16'h0000);

    // ---- redirect with simultaneous pop and final-byte ack ----
    tick();
    chk("x_lo_addr", imem_addr, 16'h0001);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("x_valid", {15'd0, instr_valid}, 16'h0000);
    chk("x_addr",  imem_addr, 16'h0040);
    chk("x_req",   {15'd0, imem_req}, 16'h0001);
    tick();
    chk("x_lo_valid", {15'd0, instr_valid}, 16'h0000);
    tick();
    chk("x_instr", instr, 16'hE5E4);
    chk("x_ipc",   instr_pc, 16'h0040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
